mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core fetch/data ports and shared memory port of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_mode;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_valid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall;
    logic                  err;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_valid, i_rdata, d_valid, d_rdata, mem_req, mem_we, mem_mode, mem_addr,
               mem_wdata, stall, err
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_valid, i_rdata, d_valid, d_rdata, mem_req, mem_we, mem_mode, mem_addr,
               mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports,
// alternating on ties and giving up on a silent memory after TIMEOUT cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;
    logic [15:0]           wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                  i_valid_q, i_valid_d, d_valid_q, d_valid_d, err_q, err_d;
    logic                  in_idle, i_ok, d_ok, grant_i, grant_d, tout, done;
    // last_q: 0 = fetch port served last, 1 = data port served last
    always_comb begin
        in_idle   = state_q == IDLE;
        i_ok      = in_idle & bus.i_req & ~i_valid_q;
        d_ok      = in_idle & bus.d_req & ~d_valid_q;
        grant_d   = d_ok & (~i_ok | ~last_q);
        grant_i   = i_ok & ~grant_d;
        tout      = ~in_idle & ~bus.mem_ready & (wait_q == WAIT_LAST);
        done      = ~in_idle & (bus.mem_ready | tout);
        state_d   = done ? IDLE : grant_d ? BUSY_D : grant_i ? BUSY_I : state_q;
        wait_d    = in_idle ? 16'd0 : wait_q + 16'd1;
        last_d    = done ? (state_q == BUSY_D) : last_q;
        addr_d    = grant_d ? bus.d_addr : grant_i ? bus.i_addr : addr_q;
        wdata_d   = grant_d ? bus.d_wdata : grant_i ? '0 : wdata_q;
        we_d      = grant_d ? bus.d_we : grant_i ? 1'b0 : we_q;
        mode_d    = grant_d ? bus.d_mode : grant_i ? 2'b10 : mode_q;
        i_valid_d = done & (state_q == BUSY_I);
        d_valid_d = done & (state_q == BUSY_D);
        err_d     = tout;
        i_rdata_d = (state_q == BUSY_I && bus.mem_ready) ? bus.mem_rdata : i_rdata_q;
        d_rdata_d = (state_q == BUSY_D && bus.mem_ready && !we_q) ? bus.mem_rdata : d_rdata_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            mode_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            mode_q    <= mode_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
        end
    end
    assign bus.mem_req   = ~in_idle;
    assign bus.mem_we    = we_q;
    assign bus.mem_mode  = mode_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall     = (bus.i_req & ~i_valid_q) | (bus.d_req & ~d_valid_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized run
// against a transaction-level model of the arbiter (TIMEOUT = 4).
module tb_mem_arbiter;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_ir;
        logic [31:0] exp_dr;
    } vec_t;
    vec_t vt [7];
    int          lat, pulses;
    logic        stable, got_d, got_err, got_mreq;
    int          m_cur, m_age;
    logic        m_last, m_iv, m_dv, m_err, m_we, n_iv, n_dv, n_err, wi, wd;
    logic [1:0]  m_mode;
    logic [31:0] m_addr, m_wdata, m_ir, m_dr;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_mode = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{1'b0, 1'b0, 2'd0, 32'h100,      32'h0,        0,  32'h13,       2, 1'b0, 32'h13,       32'h0};
        vt[1] = '{1'b1, 1'b1, 2'd2, 32'h2004,     32'hDEADBEEF, 3,  32'h55555555, 5, 1'b0, 32'h13,       32'h0};
        vt[2] = '{1'b1, 1'b0, 2'd0, 32'h3000,     32'h0,        1,  32'hCAFEF00D, 3, 1'b0, 32'h13,       32'hCAFEF00D};
        vt[3] = '{1'b0, 1'b0, 2'd0, 32'h104,      32'h0,        99, 32'h77,       5, 1'b1, 32'h13,       32'hCAFEF00D};
        vt[4] = '{1'b1, 1'b1, 2'd1, 32'h10,       32'h1234,     99, 32'h88,       5, 1'b1, 32'h13,       32'hCAFEF00D};
        vt[5] = '{1'b1, 1'b0, 2'd2, 32'h44,       32'h0,        2,  32'h0BADF00D, 4, 1'b0, 32'h13,       32'h0BADF00D};
        vt[6] = '{1'b0, 1'b0, 2'd0, 32'hFFFFFFFC, 32'h0,        3,  32'hFFFFFFFF, 5, 1'b0, 32'hFFFFFFFF, 32'h0BADF00D};
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_state", {bus.mem_req, bus.i_valid, bus.d_valid, bus.err, bus.stall, bus.mem_we,
            bus.mem_addr, bus.i_rdata, bus.d_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            if (vt[v].is_d) begin
                bus.d_req = 1; bus.d_we = vt[v].we; bus.d_mode = vt[v].mode;
                bus.d_addr = vt[v].addr; bus.d_wdata = vt[v].wdata;
            end else begin
                bus.i_req = 1; bus.i_addr = vt[v].addr; bus.d_we = 0;
            end
            #1;
            chk("vec_stall", bus.stall, 1);
            lat = 0; stable = 1; got_d = 0; got_err = 0; got_mreq = 1;
            for (int c = 1; c <= 12 && lat == 0; c++) begin
                @(negedge clk);
                if (bus.i_valid || bus.d_valid) begin
                    lat = c; got_d = bus.d_valid; got_err = bus.err; got_mreq = bus.mem_req;
                    bus.i_req = 0; bus.d_req = 0; bus.mem_ready = 0;
                end else begin
                    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, vt[v].we & vt[v].is_d, vt[v].addr})
                        stable = 0;
                    if (vt[v].is_d && {bus.mem_mode, bus.mem_wdata} !== {vt[v].mode, vt[v].wdata})
                        stable = 0;
                    bus.mem_ready = (c - 1 == vt[v].delay);
                    bus.mem_rdata = vt[v].rdata;
                end
            end
            chk("vec_latency", lat, vt[v].exp_lat);
            chk("vec_port_err", {got_d, got_err, got_mreq}, {vt[v].is_d, vt[v].exp_err, 1'b0});
            chk("vec_cmd_stable", stable, 1);
            chk("vec_rdata", {bus.i_rdata, bus.d_rdata}, {vt[v].exp_ir, vt[v].exp_dr});
            @(negedge clk);
            chk("vec_pulse_end", {bus.i_valid, bus.d_valid, bus.err}, 3'b000);
        end
        // Both ports held from reset: grants must alternate D, I, D, I with a one-cycle gap.
        @(negedge clk);
        rst = 1; bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'hA00; bus.d_addr = 32'hB00;
        bus.d_we = 0; bus.mem_ready = 0;
        #1;
        chk("tie_rst_mreq", {bus.mem_req, bus.stall}, 2'b01);
        @(negedge clk);
        rst = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("tie_mreq", bus.mem_req, c % 2);
            if (c % 2 == 1) chk("tie_addr", bus.mem_addr, (((c - 1) / 2) % 2 == 0) ? 32'hB00 : 32'hA00);
            else chk("tie_valid", {bus.i_valid, bus.d_valid}, (((c / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10);
            bus.mem_ready = bus.mem_req;
            bus.mem_rdata = c;
            if (c == 8) begin bus.i_req = 0; bus.d_req = 0; end
        end
        chk("tie_rdata", {bus.i_rdata, bus.d_rdata}, {32'd7, 32'd5});
        // Reset during a data transaction.
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'hC00; bus.d_mode = 2;
        @(negedge clk);
        chk("r28_busy", bus.mem_req, 1);
        #2;
        rst = 1; bus.mem_ready = 1;
        #1;
        chk("r28_async_drop", bus.mem_req, 0);
        @(negedge clk);
        rst = 0; bus.mem_ready = 0;
        #1;
        chk("r28_idle_after", {bus.mem_req, bus.d_valid}, 2'b00);
        @(negedge clk);
        chk("r28_reissue", {bus.mem_req, bus.d_valid, bus.mem_addr}, {2'b10, 32'hC00});
        bus.mem_ready = 1; bus.mem_rdata = 32'h28;
        @(negedge clk);
        chk("r28_done", {bus.d_valid, bus.d_rdata}, {1'b1, 32'h28});
        bus.d_req = 0; bus.mem_ready = 0;
        // Request withdrawn mid-transaction still completes exactly once.
        @(negedge clk);
        bus.d_req = 1; bus.d_addr = 32'hD00;
        @(negedge clk);
        chk("r29_busy", bus.mem_req, 1);
        bus.d_req = 0;
        @(negedge clk);
        chk("r29_no_abort", bus.mem_req, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h29;
        pulses = 0;
        for (int c = 3; c <= 7; c++) begin
            @(negedge clk);
            bus.mem_ready = 0;
            pulses += int'(bus.d_valid);
            chk("r29_no_reissue", bus.mem_req, 0);
        end
        chk("r29_pulses", {pulses, bus.d_rdata}, {32'd1, 32'h29});
        // Randomized traffic against the transaction-level model.
        do_reset();
        m_cur = 0; m_age = 0; m_last = 0; m_iv = 0; m_dv = 0; m_err = 0; m_we = 0;
        m_mode = 0; m_addr = 0; m_wdata = 0; m_ir = 0; m_dr = 0;
        for (int n = 0; n < 400; n++) begin
            if (n > 0) @(negedge clk);
            if (bus.i_req) begin
                if (m_iv ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0)) bus.i_req = 0;
            end else if ($urandom_range(1) == 1) begin
                bus.i_req = 1; bus.i_addr = $urandom & 32'hFFFFFFFC;
            end
            if (bus.d_req) begin
                if (m_dv ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0)) bus.d_req = 0;
            end else if ($urandom_range(1) == 1) begin
                bus.d_req = 1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_we = 1'($urandom_range(1)); bus.d_mode = 2'($urandom_range(2));
            end
            bus.mem_ready = ($urandom_range(2) == 0);
            bus.mem_rdata = $urandom;
            #1;
            chk("rnd_ctl", {bus.mem_req, bus.i_valid, bus.d_valid, bus.err, bus.stall},
                {m_cur != 0, m_iv, m_dv, m_err, (bus.i_req & ~m_iv) | (bus.d_req & ~m_dv)});
            if (m_cur != 0)
                chk("rnd_cmd", {bus.mem_we, bus.mem_addr, (m_cur == 2) ? {bus.mem_mode, bus.mem_wdata} : 34'd0},
                    {m_we, m_addr, (m_cur == 2) ? {m_mode, m_wdata} : 34'd0});
            chk("rnd_rdata", {bus.i_rdata, bus.d_rdata}, {m_ir, m_dr});
            n_iv = 0; n_dv = 0; n_err = 0;
            if (m_cur != 0) begin
                m_age++;
                if (bus.mem_ready || m_age == TO) begin
                    if (m_cur == 1) begin
                        n_iv = 1;
                        if (bus.mem_ready) m_ir = bus.mem_rdata;
                    end else begin
                        n_dv = 1;
                        if (bus.mem_ready && !m_we) m_dr = bus.mem_rdata;
                    end
                    n_err = !bus.mem_ready;
                    m_last = (m_cur == 2);
                    m_cur = 0;
                end
            end else begin
                wi = bus.i_req && !m_iv;
                wd = bus.d_req && !m_dv;
                m_age = 0;
                if (wd && (!wi || !m_last)) begin
                    m_cur = 2; m_addr = bus.d_addr; m_we = bus.d_we;
                    m_wdata = bus.d_wdata; m_mode = bus.d_mode;
                end else if (wi) begin
                    m_cur = 1; m_addr = bus.i_addr; m_we = 0;
                end
            end
            m_iv = n_iv; m_dv = n_dv; m_err = n_err;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
